// File: rtl/alu_issue_seq.sv
// Issue sequencer for a 32-bit combinational ALU: accepts one instruction, decodes it,
// runs a single execute cycle and hands back a write-back / branch packet.
module alu_issue_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_control_code,
  input  logic [31:0] alu_result,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

  typedef struct packed {
    logic        legal;
    logic        branch;
    logic        bne;
    logic [3:0]  code;
    logic [31:0] op2;
    logic [4:0]  dest;
  } dec_t;

  localparam logic [3:0] NOP = 4'b1111;

  state_t      state;
  logic [31:0] ins_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic        is_br;
  logic        br_ne;
  dec_t        dec;

  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [15:0] imm, input logic [31:0] rt_val);
    dec_t d;
    d.legal  = 1'b1;
    d.branch = 1'b0;
    d.bne    = 1'b0;
    d.code   = NOP;
    d.op2    = rt_val;
    d.dest   = rd;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   d.code = 4'b0010;
          6'h22:   d.code = 4'b0110;
          6'h24:   d.code = 4'b0000;
          6'h25:   d.code = 4'b0001;
          6'h26:   d.code = 4'b1101;
          6'h27:   d.code = 4'b1001;
          6'h2A:   d.code = 4'b0111;
          default: d.legal = 1'b0;
        endcase
      end
      6'h08: begin d.code = 4'b0010; d.op2 = {{16{imm[15]}}, imm}; d.dest = rt; end
      6'h0A: begin d.code = 4'b0111; d.op2 = {{16{imm[15]}}, imm}; d.dest = rt; end
      6'h0C: begin d.code = 4'b0000; d.op2 = {16'h0000, imm};      d.dest = rt; end
      6'h0D: begin d.code = 4'b0001; d.op2 = {16'h0000, imm};      d.dest = rt; end
      6'h04: begin d.code = 4'b0110; d.branch = 1'b1; end
      6'h05: begin d.code = 4'b0110; d.branch = 1'b1; d.bne = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // The rs field is not needed: rs arrives already read as rs_data.
  logic unused_rs_field;
  assign unused_rs_field = ^ins_q[25:21];

  always_comb begin
    dec = decode(ins_q[31:26], ins_q[5:0], ins_q[20:16], ins_q[15:11], ins_q[15:0], rt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      instr_ready      <= 1'b0;
      wb_valid         <= 1'b0;
      wb_we            <= 1'b0;
      wb_reg           <= '0;
      wb_data          <= '0;
      flags            <= '0;
      branch_taken     <= 1'b0;
      illegal          <= 1'b0;
      alu_control_code <= NOP;
      alu_op1          <= '0;
      alu_op2          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_ready && instr_valid) begin
            ins_q       <= instr;
            rs_q        <= rs_data;
            rt_q        <= rt_data;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        // Illegal ops bypass EXEC with a zeroed packet so the ALU never sees them.
        DECODE: begin
          if (!dec.legal) begin
            illegal      <= 1'b1;
            wb_we        <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            flags        <= '0;
            branch_taken <= 1'b0;
            wb_valid     <= 1'b1;
            state        <= DONE;
          end else begin
            alu_op1          <= rs_q;
            alu_op2          <= dec.op2;
            alu_control_code <= dec.code;
            is_br            <= dec.branch;
            br_ne            <= dec.bne;
            illegal          <= 1'b0;
            wb_we            <= !dec.branch && (dec.dest != 5'd0);
            wb_reg           <= dec.branch ? 5'd0 : dec.dest;
            state            <= EXEC;
          end
        end
        EXEC: begin
          wb_data          <= alu_result;
          flags            <= {alu_v, alu_n, alu_z};
          branch_taken     <= is_br && (alu_z ^ br_ne);
          alu_control_code <= NOP;
          alu_op1          <= '0;
          alu_op2          <= '0;
          wb_valid         <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized bench for alu_issue_seq: a behavioural ALU closes the loop and an
// instruction-level reference model predicts every write-back packet.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_control_code;
  logic [31:0] alu_result;
  logic        alu_v;
  logic        alu_n;
  logic        alu_z;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [2:0]  flags;
  logic        branch_taken;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_seq dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control_code(alu_control_code),
    .alu_result(alu_result), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_reg(wb_reg),
    .wb_data(wb_data), .flags(flags), .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU; V is signed overflow on add/sub.
  always_comb begin
    longint s;
    s          = 0;
    alu_result = '0;
    alu_v      = 1'b0;
    case (alu_control_code)
      4'b0010: begin
        s = longint'($signed(alu_op1)) + longint'($signed(alu_op2));
        alu_result = alu_op1 + alu_op2;
        alu_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = longint'($signed(alu_op1)) - longint'($signed(alu_op2));
        alu_result = alu_op1 - alu_op2;
        alu_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b1101: alu_result = alu_op1 ^ alu_op2;
      4'b1001: alu_result = ~(alu_op1 | alu_op2);
      4'b0111: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
  end

  typedef struct {
    logic        legal;
    logic        isbr;
    logic        we;
    logic        br;
    logic [3:0]  code;
    logic [31:0] op2;
    logic [31:0] data;
    logic [2:0]  flg;
    logic [4:0]  dst;
  } exp_t;

  // Instruction-level reference: what the architecture says each op produces.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    string  kind;
    longint sa, sb, r;
    logic   v;
    e.legal = 1'b1; e.isbr = 1'b0; e.br = 1'b0; e.code = 4'hF;
    e.op2 = b; e.dst = ins[15:11]; e.data = '0; e.flg = '0; e.we = 1'b0;
    kind = "";
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: kind = "add"; 6'h22: kind = "sub"; 6'h24: kind = "and";
        6'h25: kind = "or";  6'h26: kind = "xor"; 6'h27: kind = "nor";
        6'h2A: kind = "slt"; default: e.legal = 1'b0;
      endcase
      6'h08: begin kind = "add"; e.op2 = {{16{ins[15]}}, ins[15:0]}; e.dst = ins[20:16]; end
      6'h0A: begin kind = "slt"; e.op2 = {{16{ins[15]}}, ins[15:0]}; e.dst = ins[20:16]; end
      6'h0C: begin kind = "and"; e.op2 = {16'h0, ins[15:0]}; e.dst = ins[20:16]; end
      6'h0D: begin kind = "or";  e.op2 = {16'h0, ins[15:0]}; e.dst = ins[20:16]; end
      6'h04: begin kind = "sub"; e.isbr = 1'b1; e.br = (a == b); end
      6'h05: begin kind = "sub"; e.isbr = 1'b1; e.br = (a != b); end
      default: e.legal = 1'b0;
    endcase
    if (!e.legal) return e;
    sa = longint'($signed(a));
    sb = longint'($signed(e.op2));
    v  = 1'b0;
    case (kind)
      "add": begin e.code = 4'b0010; r = sa + sb; e.data = 32'(r); v = (r != longint'($signed(32'(r)))); end
      "sub": begin e.code = 4'b0110; r = sa - sb; e.data = 32'(r); v = (r != longint'($signed(32'(r)))); end
      "and": begin e.code = 4'b0000; e.data = a & e.op2; end
      "or":  begin e.code = 4'b0001; e.data = a | e.op2; end
      "xor": begin e.code = 4'b1101; e.data = a ^ e.op2; end
      "nor": begin e.code = 4'b1001; e.data = ~(a | e.op2); end
      default: begin e.code = 4'b0111; e.data = (sa < sb) ? 32'd1 : 32'd0; end
    endcase
    e.flg = {v, e.data[31], e.data == 32'd0};
    e.we  = !e.isbr && (e.dst != 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_reg", 32'(wb_reg), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_br", 32'(branch_taken), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_code", 32'(alu_control_code), 32'hF);
    chk("rst_ops", alu_op1 | alu_op2, 32'd0);
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!instr_ready && c < 10) begin step(); c++; end
    chk("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   wbc;
    logic code_ok, stable;
    logic [45:0] snap;
    e = model(ins, a, b);
    wait_ready();
    instr_valid = 1'b1; instr = ins; rs_data = a; rt_data = b;
    step();
    // Busy: keep a junk packet valid and pulse wb_ready; both must be ignored.
    instr = $urandom; rs_data = $urandom; rt_data = $urandom;
    wb_ready = 1'b1;
    chk("ready_busy", 32'(instr_ready), 32'd0);
    code_ok = 1'b1;
    wbc = 0;
    for (int k = 1; k <= 4 && wbc == 0; k++) begin
      if (k == 2) wb_ready = 1'b0;
      if (wb_valid) wbc = k;
      else if (k == 2 && e.legal) begin
        chk("exec_code", 32'(alu_control_code), 32'(e.code));
        chk("exec_op1", alu_op1, a);
        chk("exec_op2", alu_op2, e.op2);
      end else if (alu_control_code != 4'hF || alu_op1 != 0 || alu_op2 != 0) code_ok = 1'b0;
      if (instr_ready) code_ok = 1'b0;
      if (wbc == 0) step();
    end
    instr_valid = 1'b0;
    wb_ready = 1'b0;
    chk("nop_outside_exec", 32'(code_ok), 32'd1);
    chk("wb_cycle", 32'(wbc), e.legal ? 32'd3 : 32'd2);
    if (wbc == 0) return;
    chk("illegal", 32'(illegal), 32'(!e.legal));
    chk("wb_we", 32'(wb_we), 32'(e.we));
    chk("wb_data", wb_data, e.data);
    chk("flags", 32'(flags), 32'(e.flg));
    if (e.legal && !e.isbr) chk("wb_reg", 32'(wb_reg), 32'(e.dst));
    if (e.isbr) chk("branch", 32'(branch_taken), 32'(e.br));
    snap = {wb_we, wb_reg, wb_data, flags, branch_taken, illegal, instr_ready, wb_valid};
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      if ({wb_we, wb_reg, wb_data, flags, branch_taken, illegal, instr_ready, wb_valid} !== snap)
        stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("wb_drop", 32'(wb_valid), 32'd0);
    chk("ready_back", 32'(instr_ready), 32'd1);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  logic [5:0] r_funct [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [5:0] i_ops   [6] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05};
  logic [5:0] bad_ops [4] = '{6'h3F, 6'h02, 6'h23, 6'h2B};

  initial begin
    logic [31:0] ins, a, b;
    int sel;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0; wb_ready = 1'b0;
    step(); step();
    chk_reset_state();
    reset = 1'b0;
    step();
    chk("ready_after_reset", 32'(instr_ready), 32'd1);

    issue(rtype(5'd3, 6'h20), 32'd5, 32'd7, 0);
    issue(rtype(5'd4, 6'h22), 32'h1234, 32'h1234, 1);
    issue(rtype(5'd5, 6'h2A), 32'hFFFF_FFFF, 32'd1, 0);
    issue(itype(6'h08, 5'd6, 16'hFFFF), 32'd1, 32'd0, 0);
    issue(itype(6'h0D, 5'd7, 16'h8000), 32'h0000_0001, 32'd0, 0);
    issue(itype(6'h04, 5'd2, 16'h0010), 32'd9, 32'd9, 0);
    issue(itype(6'h05, 5'd2, 16'h0010), 32'd9, 32'd9, 0);
    issue(itype(6'h3F, 5'd2, 16'h1234), 32'd3, 32'd4, 0);
    issue(rtype(5'd8, 6'h00), 32'd3, 32'd4, 0);
    issue(rtype(5'd9, 6'h20), 32'h7FFF_FFFF, 32'd1, 5);
    issue(rtype(5'd0, 6'h20), 32'd5, 32'd7, 0);

    // Reset during EXEC aborts the instruction without a write-back.
    wait_ready();
    instr_valid = 1'b1; instr = rtype(5'd3, 6'h20); rs_data = 32'd5; rt_data = 32'd7;
    step();
    instr_valid = 1'b0;
    step();
    chk("pre_abort_code", 32'(alu_control_code), 32'b0010);
    reset = 1'b1;
    step();
    chk_reset_state();
    reset = 1'b0;
    sel = 0;
    for (int k = 0; k < 5; k++) begin
      if (wb_valid) sel = 1;
      step();
    end
    chk("abort_no_wb", 32'(sel), 32'd0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sel = $urandom_range(0, 15);
      if (sel < 7)
        ins = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), r_funct[sel]};
      else if (sel < 13)
        ins = {i_ops[sel-7], 5'($urandom), 5'($urandom), 16'($urandom)};
      else if (sel == 13)
        ins = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'h21};
      else
        ins = {bad_ops[$urandom_range(0, 3)], 26'($urandom)};
      issue(ins, a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
